// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) codec and its request scheduler.
package hamming_pkg;

   localparam int DATA_W = 4;
   localparam int CW_W   = 7;
   localparam int SYN_W  = 3;

   // Response tag values; also used to remember which requester was last granted.
   localparam logic TAG_ENC = 1'b0;
   localparam logic TAG_DEC = 1'b1;

   // Single output slot: either empty or holding one registered response.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/hamming74_core.sv
// Combinational Hamming(7,4) core: encodes 4 data bits or decodes and
// single-bit-corrects a 7-bit codeword, selected by mode.
module hamming74_core
   import hamming_pkg::*;
(
   input  logic              mode,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CW_W-1:0]   cw_in,
   output logic [CW_W-1:0]   res_data,
   output logic [SYN_W-1:0]  res_syndrome,
   output logic              res_corrected
);

   logic [CW_W-1:0]  enc_cw;
   logic [SYN_W-1:0] syn;
   logic [CW_W-1:0]  fixed_cw;
   logic [CW_W-1:0]  flip_mask;

   // Build the codeword: data in positions 2,4,5,6 and parity in 0,1,3.
   always_comb begin
      enc_cw    = '0;
      enc_cw[0] = data_in[0] ^ data_in[1] ^ data_in[3];
      enc_cw[1] = data_in[0] ^ data_in[2] ^ data_in[3];
      enc_cw[2] = data_in[0];
      enc_cw[3] = data_in[1] ^ data_in[2] ^ data_in[3];
      enc_cw[4] = data_in[1];
      enc_cw[5] = data_in[2];
      enc_cw[6] = data_in[3];
   end

   // Syndrome points at the 1-based position of a single flipped bit; flip it back.
   always_comb begin
      syn[0]    = cw_in[0] ^ cw_in[2] ^ cw_in[4] ^ cw_in[6];
      syn[1]    = cw_in[1] ^ cw_in[2] ^ cw_in[5] ^ cw_in[6];
      syn[2]    = cw_in[3] ^ cw_in[4] ^ cw_in[5] ^ cw_in[6];
      flip_mask = '0;
      if (syn != '0) begin
         flip_mask = 7'd1 << (syn - 3'd1);
      end
      fixed_cw = cw_in ^ flip_mask;
   end

   // Present either the codeword or the zero-extended corrected data.
   always_comb begin
      res_data      = enc_cw;
      res_syndrome  = '0;
      res_corrected = 1'b0;
      if (mode == TAG_DEC) begin
         res_data      = {3'b000, fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
         res_syndrome  = syn;
         res_corrected = (syn != '0);
      end
   end

endmodule

// File: rtl/hamming_codec_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) core between an encode and a
// decode request channel, with a one-entry registered response slot and a
// saturating count of corrected decodes.
module hamming_codec_sched
   import hamming_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              enc_valid,
   output logic              enc_ready,
   input  logic [DATA_W-1:0] enc_data,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [CW_W-1:0]   dec_cw,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_tag,
   output logic [CW_W-1:0]   rsp_data,
   output logic [SYN_W-1:0]  rsp_syndrome,
   output logic              rsp_corrected,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   slot_state_e      state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp_tag_q, rsp_tag_d;
   logic [CW_W-1:0]  rsp_data_q, rsp_data_d;
   logic [SYN_W-1:0] rsp_syn_q, rsp_syn_d;
   logic             rsp_corr_q, rsp_corr_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             grant_enc;
   logic             grant_dec;
   logic             slot_free;
   logic             accept_ok;
   logic             accept;

   logic [CW_W-1:0]  core_data;
   logic [SYN_W-1:0] core_syn;
   logic             core_corr;

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
   always_comb begin
      grant_enc = enc_valid & (~dec_valid | (last_grant_q == TAG_DEC));
      grant_dec = dec_valid & (~enc_valid | (last_grant_q == TAG_ENC));
      slot_free = (state_q == SLOT_EMPTY) | rsp_ready;
      accept_ok = rst_n & ena & slot_free;
      enc_ready = accept_ok & grant_enc;
      dec_ready = accept_ok & grant_dec;
      accept    = enc_ready | dec_ready;
   end

   hamming74_core u_core (
      .mode          (grant_dec),
      .data_in       (enc_data),
      .cw_in         (dec_cw),
      .res_data      (core_data),
      .res_syndrome  (core_syn),
      .res_corrected (core_corr)
   );

   // Slot occupancy, response capture and error counting for the next edge.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_data_d   = rsp_data_q;
      rsp_syn_d    = rsp_syn_q;
      rsp_corr_d   = rsp_corr_q;
      err_cnt_d    = err_cnt_q;

      case (state_q)
         SLOT_EMPTY: begin
            if (accept) begin
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (rsp_ready & ~accept) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: begin
            state_d = SLOT_EMPTY;
         end
      endcase

      if (accept) begin
         last_grant_d = grant_dec ? TAG_DEC : TAG_ENC;
         rsp_tag_d    = grant_dec ? TAG_DEC : TAG_ENC;
         rsp_data_d   = core_data;
         rsp_syn_d    = core_syn;
         rsp_corr_d   = core_corr;
      end

      if (cnt_clr) begin
         err_cnt_d = '0;
      end else if (dec_ready & core_corr & (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   // State registers; reset empties the slot and biases the first tie toward encode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SLOT_EMPTY;
         last_grant_q <= TAG_DEC;
         rsp_tag_q    <= 1'b0;
         rsp_data_q   <= '0;
         rsp_syn_q    <= '0;
         rsp_corr_q   <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_data_q   <= rsp_data_d;
         rsp_syn_q    <= rsp_syn_d;
         rsp_corr_q   <= rsp_corr_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign rsp_valid     = (state_q == SLOT_FULL);
   assign rsp_tag       = rsp_tag_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_syndrome  = rsp_syn_q;
   assign rsp_corrected = rsp_corr_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_hamming_codec_sched.sv
// Scoreboard bench for hamming_codec_sched: a behavioural model predicts grants,
// slot occupancy and the error counter; expected responses queue on accept and
// are compared while the DUT presents them.
module tb_hamming_codec_sched;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic             enc_valid;
   logic             enc_ready;
   logic [3:0]       enc_data;
   logic             dec_valid;
   logic             dec_ready;
   logic [6:0]       dec_cw;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_tag;
   logic [6:0]       rsp_data;
   logic [2:0]       rsp_syndrome;
   logic             rsp_corrected;
   logic             cnt_clr;
   logic [CNT_W-1:0] err_cnt;

   typedef struct packed {
      logic       tag;
      logic [6:0] data;
      logic [2:0] syn;
      logic       corr;
   } rsp_t;

   rsp_t             expQ[$];
   int               assertCount;
   int               failCount;
   logic             modelFull;
   logic             modelLast;
   logic [CNT_W-1:0] modelCnt;

   always #5 clk = ~clk;

   hamming_codec_sched #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .enc_valid     (enc_valid),
      .enc_ready     (enc_ready),
      .enc_data      (enc_data),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_cw        (dec_cw),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_tag       (rsp_tag),
      .rsp_data      (rsp_data),
      .rsp_syndrome  (rsp_syndrome),
      .rsp_corrected (rsp_corrected),
      .cnt_clr       (cnt_clr),
      .err_cnt       (err_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Syndrome as the XOR of 1-based positions of all set bits.
   function automatic logic [2:0] posXor(input logic [6:0] c);
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 7; i++) begin
         if (c[i]) s = s ^ 3'(i + 1);
      end
      return s;
   endfunction

   function automatic rsp_t modelResponse(input logic isDec, input logic [3:0] d, input logic [6:0] cw);
      logic [6:0] c;
      logic [2:0] s;
      rsp_t       r;
      if (!isDec) begin
         c    = '0;
         c[2] = d[0];
         c[4] = d[1];
         c[5] = d[2];
         c[6] = d[3];
         s    = posXor(c);
         c[0] = s[0];
         c[1] = s[1];
         c[3] = s[2];
         r.tag  = 1'b0;
         r.data = c;
         r.syn  = 3'b000;
         r.corr = 1'b0;
      end else begin
         c = cw;
         s = posXor(c);
         if (s != 3'b000) c[int'(s) - 1] = ~c[int'(s) - 1];
         r.tag  = 1'b1;
         r.data = {3'b000, c[6], c[5], c[4], c[2]};
         r.syn  = s;
         r.corr = (s != 3'b000);
      end
      return r;
   endfunction

   task automatic modelReset();
      expQ.delete();
      modelFull = 1'b0;
      modelLast = 1'b1;
      modelCnt  = '0;
   endtask

   task automatic applyStimulus(input logic ev, input logic [3:0] ed, input logic dv, input logic [6:0] dc,
                                input logic rr, input logic en, input logic clr);
      logic slotFree, ge, gd, expEnc, expDec;
      rsp_t e;
      rsp_t n;
      enc_valid = ev;
      enc_data  = ed;
      dec_valid = dv;
      dec_cw    = dc;
      rsp_ready = rr;
      ena       = en;
      cnt_clr   = clr;
      @(negedge clk);
      slotFree = ~modelFull | rr;
      ge       = ev & (~dv | modelLast);
      gd       = dv & (~ev | ~modelLast);
      expEnc   = en & slotFree & ge;
      expDec   = en & slotFree & gd;
      checkOutput("rsp_valid", rsp_valid, modelFull);
      if (modelFull) begin
         if (expQ.size() == 0) begin
            checkOutput("scoreboard_nonempty", 0, 1);
         end else begin
            e = expQ[0];
            checkOutput("rsp_tag", rsp_tag, e.tag);
            checkOutput("rsp_data", rsp_data, e.data);
            checkOutput("rsp_syndrome", rsp_syndrome, e.syn);
            checkOutput("rsp_corrected", rsp_corrected, e.corr);
            if (rr) void'(expQ.pop_front());
         end
      end
      checkOutput("enc_ready", enc_ready, expEnc);
      checkOutput("dec_ready", dec_ready, expDec);
      checkOutput("err_cnt", err_cnt, modelCnt);
      n = modelResponse(expDec, ed, dc);
      if (expEnc | expDec) begin
         expQ.push_back(n);
         modelLast = expDec;
      end
      if (clr) modelCnt = '0;
      else if (expDec & n.corr & (modelCnt != '1)) modelCnt = modelCnt + 1'b1;
      modelFull = expEnc | expDec | (modelFull & ~rr);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'h0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n     = 1'b0;
      ena       = 1'b1;
      enc_valid = 1'b1;
      dec_valid = 1'b1;
      enc_data  = 4'hB;
      dec_cw    = 7'h45;
      rsp_ready = 1'b1;
      cnt_clr   = 1'b0;
      modelReset();
      #2;
      $display("[TB] reset state");
      checkOutput("rst_enc_ready", enc_ready, 0);
      checkOutput("rst_dec_ready", dec_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_data", rsp_data, 0);
      checkOutput("rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] round-robin with both requesters valid");
      applyStimulus(1'b1, 4'h0, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("rr_first_tag", rsp_tag, 0);
      applyStimulus(1'b1, 4'hF, 1'b1, 7'h7F, 1'b1, 1'b1, 1'b0);
      checkOutput("rr_second_tag", rsp_tag, 1);
      applyStimulus(1'b1, 4'h5, 1'b1, 7'h55, 1'b1, 1'b1, 1'b0);
      checkOutput("rr_third_tag", rsp_tag, 0);
      applyStimulus(1'b1, 4'hA, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("rr_fourth_tag", rsp_tag, 1);
      idle();

      $display("[TB] encode and decode vectors");
      applyStimulus(1'b1, 4'hB, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("encB_data", rsp_data, 7'h55);
      checkOutput("encB_syn", rsp_syndrome, 0);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h45, 1'b1, 1'b1, 1'b0);
      checkOutput("dec45_data", rsp_data, 7'h0B);
      checkOutput("dec45_syn", rsp_syndrome, 3'b101);
      checkOutput("dec45_corr", rsp_corrected, 1);
      checkOutput("dec45_cnt", err_cnt, 1);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h55, 1'b1, 1'b1, 1'b0);
      checkOutput("dec55_syn", rsp_syndrome, 0);
      checkOutput("dec55_cnt", err_cnt, 1);
      idle();

      $display("[TB] backpressure");
      applyStimulus(1'b1, 4'h6, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 4'h9, 1'b1, 7'h46, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'h9, 1'b1, 7'h46, 1'b1, 1'b1, 1'b0);
      checkOutput("drain_accept_valid", rsp_valid, 1);
      idle();

      $display("[TB] counter saturation and clear");
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h54, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h57, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h51, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h5D, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h15, 1'b1, 1'b1, 1'b0);
      checkOutput("cnt_saturated", err_cnt, 3);
      applyStimulus(1'b0, 4'h0, 1'b1, 7'h01, 1'b1, 1'b1, 1'b1);
      checkOutput("cnt_clr_priority", err_cnt, 0);
      idle();

      $display("[TB] ena low drains without accepting");
      applyStimulus(1'b1, 4'h2, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 4'h3, 1'b1, 7'h33, 1'b1, 1'b0, 1'b0);
      checkOutput("ena_low_empty", rsp_valid, 0);
      idle();

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0),
                       1'($urandom_range(0, 15) == 0));
      end
      idle();
      idle();

      $display("[TB] asynchronous reset while full");
      applyStimulus(1'b1, 4'hA, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
      checkOutput("pre_reset_valid", rsp_valid, 1);
      enc_valid = 1'b1;
      dec_valid = 1'b1;
      rsp_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", rsp_valid, 0);
      checkOutput("async_rst_data", rsp_data, 0);
      checkOutput("async_rst_enc_ready", enc_ready, 0);
      checkOutput("async_rst_dec_ready", dec_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      applyStimulus(1'b1, 4'h1, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("post_reset_first_grant", rsp_tag, 0);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/hamming_codec_sched.md
HAMMING_CODEC_SCHED -- requirements
Module: hamming_codec_sched

Interface
REQ-001 Parameter CNT_W, default 8: width of the corrected-error counter.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ena  in  1  high = grants permitted; low = no new accepts, output still drains.
REQ-005 enc_valid  in  1, enc_ready  out  1, enc_data  in  4: encode request channel.
REQ-006 dec_valid  in  1, dec_ready  out  1, dec_cw  in  7: decode request channel.
REQ-007 rsp_valid  out  1, rsp_ready  in  1: response handshake.
REQ-008 rsp_tag  out  1: 0 = encode response, 1 = decode response.
REQ-009 rsp_data  out  7: encode = codeword; decode = {3'b000, corrected data}.
REQ-010 rsp_syndrome  out  3, rsp_corrected  out  1: decode syndrome and nonzero flag; both 0 for encode.
REQ-011 cnt_clr  in  1, err_cnt  out  CNT_W: synchronous clear and saturating count of corrected decodes.

Function
REQ-012 Codeword layout: cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3.
REQ-013 Parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
REQ-014 Syndrome bits: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6; syndrome = {s4,s2,s1}.
REQ-015 Nonzero syndrome S: flip cw[S-1] before data extraction and set rsp_corrected=1.
REQ-016 Output slot FSM: states EMPTY and FULL; EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL stays FULL on rsp_ready with accept (new result loaded).
REQ-017 slot_free = (state==EMPTY) | rsp_ready; a request is accepted only when ena & slot_free & granted.
REQ-018 Arbitration: a sole valid requester is granted; if both are valid, grant the one not granted last (round-robin); last_grant updates only on an accept.
REQ-019 enc_ready/dec_ready are high only for the granted requester in an accepting cycle; they may depend on valid; rsp_valid never depends on rsp_ready.
REQ-020 Latency: request accepted at edge N gives its registered response with rsp_valid=1 after edge N; throughput 1 response/cycle when rsp_ready is held high.
REQ-021 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
REQ-022 err_cnt increments by 1 on each accepted decode with nonzero syndrome and saturates at 2^CNT_W-1.
REQ-023 cnt_clr has priority: a correction coinciding with cnt_clr leaves err_cnt=0.
REQ-024 ena deasserted while FULL: the pending response still completes; no accept occurs until ena returns high.

Reset
REQ-025 On rst_n low, asynchronously: state=EMPTY, rsp_valid=0, rsp_tag=0, rsp_data=0, rsp_syndrome=0, rsp_corrected=0, err_cnt=0, last_grant=decode.
REQ-026 Reset mid-transaction discards the pending response; enc_ready=dec_ready=0 while rst_n is low.
REQ-027 After release, the first simultaneous request pair grants encode.

Structure
REQ-028 Shared package hamming_pkg holds: TAG_ENC/TAG_DEC constants, data/codeword/syndrome widths, and the slot-state enum.
REQ-029 One combinational sub-module, hamming74_core, implements REQ-012..REQ-015 in encode and decode modes; the scheduler instantiates it once, time-shared.

Verification
REQ-030 Encode 4'hB, rsp_ready=1 -> next cycle rsp_tag=0, rsp_data=7'h55, syndrome=0, corrected=0.
REQ-031 Decode 7'h45 -> rsp_data=7'h0B, syndrome=3'b101, corrected=1, err_cnt 0->1; decode 7'h55 -> syndrome 0, err_cnt unchanged.
REQ-032 Both valid for 4 cycles after reset, rsp_ready=1 -> grant order enc, dec, enc, dec with one response per cycle.
REQ-033 rsp_ready=0 for 3 cycles with response pending -> outputs stable, both readies 0; rsp_ready=1 -> drain plus new accept in the same cycle.
REQ-034 CNT_W=2, five corrected decodes -> err_cnt saturates at 3; cnt_clr together with a correction -> err_cnt=0.
REQ-035 rst_n low while FULL -> rsp_valid drops immediately without a clock edge; ena=0 -> no accepts while a pending response still drains.
